mul_product_writeback: RTL and testbench

- Stage directly downstream of the 32x32 Booth multiplier.
- Accepts the 64-bit signed product through a valid/ready handshake and holds it.
- Writes the product onto the shared 32-bit datapath bus as two arbitrated transfers, LO half and HI half, with write strobes to the LO and HI registers.
- Produces sticky status flags (zero, 32-bit overflow) and a completion pulse for the control unit.

---
 rtl/mul_product_writeback.sv | 103 ++++++++++
 tb/tb_mul_product_writeback.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_product_writeback.sv
// rtl/mul_product_writeback.sv - holds a multiplier product and writes it to the bus as two halves
// Status flags are captured with the product; done pulses the cycle after the last half is written.
module mul_product_writeback #(
  parameter int WIDTH    = 32,
  parameter bit HI_FIRST = 1'b0
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               prod_valid,
  input  logic [2*WIDTH-1:0] prod_data,
  output logic               prod_ready,
  output logic               bus_req,
  input  logic               bus_grant,
  output logic               bus_drive,
  output logic [WIDTH-1:0]   bus_data,
  output logic               lo_write,
  output logic               hi_write,
  output logic               busy,
  output logic               done,
  output logic               zero_flag,
  output logic               ovf_flag
);

  typedef enum logic [1:0] {IDLE, XFER1, XFER2} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [2*WIDTH-1:0] r_hold;
  logic               r_zero;
  logic               r_ovf;
  logic               r_done;
  logic               w_active;
  logic               w_xfer_hi;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_hold <= '0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == XFER2) && bus_grant;
      if ((r_state == IDLE) && prod_valid) begin
        r_hold <= prod_data;
        r_zero <= (prod_data == '0);
        // Overflow when the upper half is not a pure sign extension of the lower half.
        r_ovf  <= (prod_data[2*WIDTH-1:WIDTH] != {WIDTH{prod_data[WIDTH-1]}});
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    prod_ready = 1'b0;
    busy       = 1'b0;
    bus_req    = 1'b0;
    w_active   = 1'b0;
    w_xfer_hi  = 1'b0;
    case (r_state)
      IDLE: begin
        prod_ready = 1'b1;
        if (prod_valid) w_next = XFER1;
      end
      XFER1: begin
        busy      = 1'b1;
        bus_req   = 1'b1;
        w_xfer_hi = HI_FIRST;
        w_active  = bus_grant;
        if (bus_grant) w_next = XFER2;
      end
      XFER2: begin
        busy      = 1'b1;
        bus_req   = 1'b1;
        w_xfer_hi = !HI_FIRST;
        w_active  = bus_grant;
        if (bus_grant) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase

    // Bus outputs exist only in a granted cycle, so an ungranted stall drives nothing.
    bus_drive = w_active;
    lo_write  = w_active && !w_xfer_hi;
    hi_write  = w_active && w_xfer_hi;
    bus_data  = '0;
    if (w_active) begin
      bus_data = w_xfer_hi ? r_hold[2*WIDTH-1:WIDTH] : r_hold[WIDTH-1:0];
    end
  end

  assign done      = r_done;
  assign zero_flag = r_zero;
  assign ovf_flag  = r_ovf;

endmodule

// File: tb/tb_mul_product_writeback.sv
// tb/tb_mul_product_writeback.sv - directed bench for mul_product_writeback
// Covers both half orderings, bus stalls, ignored input while busy and mid-transfer reset.
module tb_mul_product_writeback;

  logic        clock;
  logic        clear_n;
  logic        prod_valid, prod_ready, bus_req, bus_grant, bus_drive;
  logic [63:0] prod_data;
  logic [31:0] bus_data;
  logic        lo_write, hi_write, busy, done, zero_flag, ovf_flag;

  logic        hf_valid, hf_ready, hf_req, hf_grant, hf_drive;
  logic [63:0] hf_data;
  logic [31:0] hf_bus_data;
  logic        hf_lo_write, hf_hi_write, hf_busy, hf_done, hf_zero, hf_ovf;

  int total = 0;
  int bad   = 0;

  mul_product_writeback #(.WIDTH(32), .HI_FIRST(1'b0)) u_dut (
    .clock(clock), .clear_n(clear_n), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_ready(prod_ready), .bus_req(bus_req), .bus_grant(bus_grant), .bus_drive(bus_drive),
    .bus_data(bus_data), .lo_write(lo_write), .hi_write(hi_write), .busy(busy), .done(done),
    .zero_flag(zero_flag), .ovf_flag(ovf_flag)
  );

  mul_product_writeback #(.WIDTH(32), .HI_FIRST(1'b1)) u_hf (
    .clock(clock), .clear_n(clear_n), .prod_valid(hf_valid), .prod_data(hf_data),
    .prod_ready(hf_ready), .bus_req(hf_req), .bus_grant(hf_grant), .bus_drive(hf_drive),
    .bus_data(hf_bus_data), .lo_write(hf_lo_write), .hi_write(hf_hi_write), .busy(hf_busy),
    .done(hf_done), .zero_flag(hf_zero), .ovf_flag(hf_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  // Accepts p with grant held high and checks both writes; returns inside the done cycle.
  task automatic xfer(input logic [63:0] p, input logic [31:0] exp_first,
                      input logic [31:0] exp_second, input logic zf, input logic of);
    prod_valid = 1'b1;
    prod_data  = p;
    clk1();
    prod_valid = 1'b0;
    #1;
    chk("x1_busy", busy, 1);
    chk("x1_ready", prod_ready, 0);
    chk("x1_req", bus_req, 1);
    chk("x1_drive", bus_drive, 1);
    chk("x1_data", bus_data, exp_first);
    chk("x1_lo_write", lo_write, 1);
    chk("x1_hi_write", hi_write, 0);
    chk("x1_done", done, 0);
    chk("x1_zero", zero_flag, zf);
    chk("x1_ovf", ovf_flag, of);
    clk1();
    #1;
    chk("x2_data", bus_data, exp_second);
    chk("x2_lo_write", lo_write, 0);
    chk("x2_hi_write", hi_write, 1);
    chk("x2_drive", bus_drive, 1);
    clk1();
    #1;
    chk("d_done", done, 1);
    chk("d_ready", prod_ready, 1);
    chk("d_busy", busy, 0);
    chk("d_req", bus_req, 0);
    chk("d_drive", bus_drive, 0);
    chk("d_data", bus_data, 0);
    chk("d_zero", zero_flag, zf);
    chk("d_ovf", ovf_flag, of);
  endtask

  initial begin
    clear_n    = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    bus_grant  = 1'b1;
    hf_valid   = 1'b0;
    hf_data    = '0;
    hf_grant   = 1'b1;
    #3;
    chk("rst_req", bus_req, 0);
    chk("rst_drive", bus_drive, 0);
    chk("rst_data", bus_data, 0);
    chk("rst_lo", lo_write, 0);
    chk("rst_hi", hi_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_ovf", ovf_flag, 0);
    clk1();
    clk1();
    clear_n = 1'b1;
    #1;
    chk("rel_ready", prod_ready, 1);

    xfer(64'h00000000_00000006, 32'h00000006, 32'h00000000, 1'b0, 1'b0);
    clk1();
    chk("done_one_cycle", done, 0);
    xfer(64'hFFFFFFFF_FFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0);
    clk1();
    xfer(64'h00000001_00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b1);
    clk1();
    xfer(64'h00000000_00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    // Accept issued inside the done cycle of the previous product.
    xfer(64'h00000000_80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1);
    clk1();

    // Stalled grant, with a conflicting product offered while busy.
    bus_grant  = 1'b0;
    prod_valid = 1'b1;
    prod_data  = 64'h00000000_00000022;
    clk1();
    prod_data = 64'h12345678_9ABCDEF0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("s1_req", bus_req, 1);
      chk("s1_lo", lo_write, 0);
      chk("s1_hi", hi_write, 0);
      chk("s1_drive", bus_drive, 0);
      chk("s1_data", bus_data, 0);
      clk1();
    end
    prod_valid = 1'b0;
    bus_grant  = 1'b1;
    #1;
    chk("s1_go_lo", lo_write, 1);
    chk("s1_go_data", bus_data, 32'h00000022);
    clk1();
    bus_grant = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("s2_req", bus_req, 1);
      chk("s2_lo", lo_write, 0);
      chk("s2_hi", hi_write, 0);
      chk("s2_data", bus_data, 0);
      chk("s2_done", done, 0);
      clk1();
    end
    bus_grant = 1'b1;
    #1;
    chk("s2_go_hi", hi_write, 1);
    chk("s2_go_data", bus_data, 32'h00000000);
    chk("s_zero_kept", zero_flag, 0);
    chk("s_ovf_kept", ovf_flag, 0);
    clk1();
    chk("s_done", done, 1);
    clk1();
    chk("s_done_end", done, 0);

    // Reset while the HI half is on the bus.
    prod_valid = 1'b1;
    prod_data  = 64'h00000005_00000007;
    clk1();
    prod_valid = 1'b0;
    clk1();
    chk("r_pre_hi", hi_write, 1);
    chk("r_pre_data", bus_data, 32'h00000005);
    chk("r_pre_ovf", ovf_flag, 1);
    #1;
    clear_n = 1'b0;
    #1;
    chk("r_req", bus_req, 0);
    chk("r_drive", bus_drive, 0);
    chk("r_data", bus_data, 0);
    chk("r_lo", lo_write, 0);
    chk("r_hi", hi_write, 0);
    chk("r_busy", busy, 0);
    chk("r_ovf", ovf_flag, 0);
    chk("r_zero", zero_flag, 0);
    chk("r_done", done, 0);
    clk1();
    chk("r_done_edge", done, 0);
    clear_n = 1'b1;
    #1;
    chk("r_ready", prod_ready, 1);
    clk1();
    chk("r_no_done", done, 0);
    xfer(64'h00000000_7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b0);
    clk1();

    // HI-first ordering.
    hf_valid = 1'b1;
    hf_data  = 64'hAAAAAAAA_55555555;
    clk1();
    hf_valid = 1'b0;
    #1;
    chk("hf1_data", hf_bus_data, 32'hAAAAAAAA);
    chk("hf1_hi", hf_hi_write, 1);
    chk("hf1_lo", hf_lo_write, 0);
    chk("hf_ovf", hf_ovf, 1);
    chk("hf_zero", hf_zero, 0);
    clk1();
    #1;
    chk("hf2_data", hf_bus_data, 32'h55555555);
    chk("hf2_lo", hf_lo_write, 1);
    chk("hf2_hi", hf_hi_write, 0);
    clk1();
    #1;
    chk("hf_done", hf_done, 1);
    chk("hf_ready", hf_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
